// File: rtl/cgra_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// cgra_clk_gate_ctrl
//
// Multi-channel clock-gating controller for the CGRA subsystem.
//
// Each channel has its own four-state FSM (RUN / IDLE / GATED / WAKE) with the
// following behaviour:
//   - Idle hysteresis: a channel is gated only after idle_thr_i consecutive
//     idle samples.
//   - Timed wake-up: the clock runs for WAKE_CYC cycles after ungating, then
//     wake_ack_o pulses for one cycle.
//   - Overrides: force_on_i keeps a channel's clock on; test_en_i forces every
//     gate enable high.
//
// Parameters:
//   N_CH     : number of independently gated channels
//   CNT_W    : width of the idle counter and of idle_thr_i
//   WAKE_CYC : clock cycles after ungating before wake_ack_o
//   STAT_W   : width of each gated-cycle counter (statistics build only)
//
// Ports:
//   clk_i          : free-running clock
//   rst_i          : synchronous, active-high reset
//   test_en_i      : scan/test, combinationally forces gate_en_o to all ones
//   idle_thr_i     : idle samples needed before gating; 0 disables auto-gating
//   busy_i         : per-channel activity
//   force_on_i     : per-channel keep-clock-on override
//   wake_req_i     : per-channel wake request (level)
//   wake_ack_o     : per-channel one-cycle "clock running and stable" pulse
//   gate_en_o      : per-channel enable to the external clock-gate cell
//   gated_o        : per-channel status, 1 while the FSM is in GATED
//   stat_clr_i     : clears all gated-cycle counters
//   gated_cycles_o : per-channel gated-cycle counts, channel k at
//                    [k*STAT_W +: STAT_W]
//
// Optional feature, macro CGRA_CLK_GATE_STATS_EN:
//   - Defined: saturating per-channel counters of cycles where the effective
//     gate_en_o is 0. stat_clr_i wins over a same-cycle increment.
//   - Undefined: gated_cycles_o is tied to zero and stat_clr_i is ignored.
// -----------------------------------------------------------------------------
module cgra_clk_gate_ctrl #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2,
    parameter int STAT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     test_en_i,
    input  logic [CNT_W-1:0]         idle_thr_i,
    input  logic [N_CH-1:0]          busy_i,
    input  logic [N_CH-1:0]          force_on_i,
    input  logic [N_CH-1:0]          wake_req_i,
    output logic [N_CH-1:0]          wake_ack_o,
    output logic [N_CH-1:0]          gate_en_o,
    output logic [N_CH-1:0]          gated_o,
    input  logic                     stat_clr_i,
    output logic [N_CH*STAT_W-1:0]   gated_cycles_o
);

    localparam int WK_W = (WAKE_CYC < 1) ? 1 : $clog2(WAKE_CYC + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    logic thr_zero;
    assign thr_zero = (idle_thr_i == '0);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [WK_W-1:0]  wcnt_q, wcnt_d;
        logic             ack_q, ack_d;
        logic             gate_q, gated_q;
        logic             idle_s, wake_s;
        logic [CNT_W:0]   cnt_inc;
        logic [WK_W:0]    wcnt_inc;

        assign wake_s   = busy_i[k] | force_on_i[k] | wake_req_i[k];
        assign idle_s   = !wake_s && !thr_zero;
        // One extra bit so the increment never wraps before the compare.
        assign cnt_inc  = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
        assign wcnt_inc = (WK_W+1)'(wcnt_q) + (WK_W+1)'(1);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_RUN;
                cnt_q   <= '0;
                wcnt_q  <= '0;
                ack_q   <= 1'b0;
                gate_q  <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wcnt_q  <= wcnt_d;
                ack_q   <= ack_d;
                // Decoded from next state so the enable leaves a flop directly.
                gate_q  <= (state_d != ST_GATED);
                gated_q <= (state_d == ST_GATED);
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wcnt_d  = wcnt_q;
            ack_d   = 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (idle_s) begin
                        // First idle sample already counts as one; with a
                        // threshold of 1 it gates immediately.
                        if (idle_thr_i == CNT_W'(1)) begin
                            state_d = ST_GATED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                        ack_d = wake_req_i[k];
                    end
                end
                ST_IDLE: begin
                    if (idle_s) begin
                        // Threshold is compared live, so lowering it below
                        // the count gates on the next idle sample.
                        if (cnt_inc >= {1'b0, idle_thr_i}) begin
                            state_d = ST_GATED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        ack_d   = wake_req_i[k];
                    end
                end
                ST_GATED: begin
                    if (wake_s) begin
                        state_d = ST_WAKE;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                    end
                end
                ST_WAKE: begin
                    // Inputs are ignored until the clock has run WAKE_CYC edges.
                    if (wcnt_inc >= (WK_W+1)'(WAKE_CYC)) begin
                        state_d = ST_RUN;
                        wcnt_d  = '0;
                        ack_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_inc[WK_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end
            endcase
        end

        assign gate_en_o[k]  = gate_q | test_en_i;
        assign gated_o[k]    = gated_q;
        assign wake_ack_o[k] = ack_q;

`ifdef CGRA_CLK_GATE_STATS_EN
        logic [STAT_W-1:0] stat_q;

        // Counts cycles where the effective enable is low, so test mode
        // cycles are not counted even while the FSM sits in GATED.
        always_ff @(posedge clk_i) begin
            if (rst_i || stat_clr_i) begin
                stat_q <= '0;
            end else if (!gate_q && !test_en_i && (stat_q != '1)) begin
                stat_q <= stat_q + STAT_W'(1);
            end
        end

        assign gated_cycles_o[k*STAT_W +: STAT_W] = stat_q;
`endif
    end

`ifndef CGRA_CLK_GATE_STATS_EN
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr_i;
    assign gated_cycles_o  = '0;
`endif

endmodule
